// File: rtl/reg_file_sb.sv
// Dual-read, dual-write register file with a per-register busy scoreboard.
// Write port 0 has priority on address collisions; busy_cnt_o tracks the number of busy registers.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic              rs_busy_o,
    output logic              rt_busy_o,
    input  logic              w0_en_i,
    input  logic [ADDR_W-1:0] w0_addr_i,
    input  logic [DATA_W-1:0] w0_data_i,
    input  logic              w1_en_i,
    input  logic [ADDR_W-1:0] w1_addr_i,
    input  logic [DATA_W-1:0] w1_data_i,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    output logic [ADDR_W:0]   busy_cnt_o
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              w0_eff, w1_eff, rsv_eff;
    logic              cnt_inc, cnt_dec0, cnt_dec1;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        w0_eff  = w0_en_i  && !is_zero(w0_addr_i);
        w1_eff  = w1_en_i  && !is_zero(w1_addr_i);
        rsv_eff = rsv_en_i && !is_zero(rsv_addr_i);
    end

    // w0 is applied after w1 so it wins a same-address collision; the reservation is applied last.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (w1_eff) begin
            regs_d[w1_addr_i] = w1_data_i;
            busy_d[w1_addr_i] = 1'b0;
        end
        if (w0_eff) begin
            regs_d[w0_addr_i] = w0_data_i;
            busy_d[w0_addr_i] = 1'b0;
        end
        if (rsv_eff) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
    end

    // Each touched address contributes at most once, so the count moves by -2..+1.
    always_comb begin
        cnt_inc  = rsv_eff && !busy_q[rsv_addr_i];
        cnt_dec0 = w0_eff && busy_q[w0_addr_i]
                   && !(rsv_eff && (rsv_addr_i == w0_addr_i));
        cnt_dec1 = w1_eff && busy_q[w1_addr_i]
                   && !(rsv_eff && (rsv_addr_i == w1_addr_i))
                   && !(w0_eff && (w0_addr_i == w1_addr_i));
        busy_cnt_d = busy_cnt_q
                     + {{ADDR_W{1'b0}}, cnt_inc}
                     - {{ADDR_W{1'b0}}, cnt_dec0}
                     - {{ADDR_W{1'b0}}, cnt_dec1};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        rs_data_o = regs_q[rs_addr_i];
        rs_busy_o = busy_q[rs_addr_i];
        if (BYPASS != 0) begin
            if (w0_eff && (w0_addr_i == rs_addr_i)) begin
                rs_data_o = w0_data_i;
                rs_busy_o = 1'b0;
            end else if (w1_eff && (w1_addr_i == rs_addr_i)) begin
                rs_data_o = w1_data_i;
                rs_busy_o = 1'b0;
            end
        end
        if (is_zero(rs_addr_i)) begin
            rs_data_o = '0;
            rs_busy_o = 1'b0;
        end
    end

    always_comb begin
        rt_data_o = regs_q[rt_addr_i];
        rt_busy_o = busy_q[rt_addr_i];
        if (BYPASS != 0) begin
            if (w0_eff && (w0_addr_i == rt_addr_i)) begin
                rt_data_o = w0_data_i;
                rt_busy_o = 1'b0;
            end else if (w1_eff && (w1_addr_i == rt_addr_i)) begin
                rt_data_o = w1_data_i;
                rt_busy_o = 1'b0;
            end
        end
        if (is_zero(rt_addr_i)) begin
            rt_data_o = '0;
            rt_busy_o = 1'b0;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array-based reference model.
module tb_reg_file_sb;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] rs_a, rt_a, w0_a, w1_a, rsv_a;
    logic          w0_en, w1_en, rsv_en;
    logic [DW-1:0] w0_d, w1_d;

    logic [DW-1:0] rs_d_b, rt_d_b, rs_d_n, rt_d_n;
    logic          rs_bz_b, rt_bz_b, rs_bz_n, rt_bz_n;
    logic [AW:0]   cnt_b, cnt_n;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_m  [NREG];
    bit            busy_m [NREG];

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(1)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .rs_addr_i(rs_a), .rt_addr_i(rt_a),
        .rs_data_o(rs_d_b), .rt_data_o(rt_d_b),
        .rs_busy_o(rs_bz_b), .rt_busy_o(rt_bz_b),
        .w0_en_i(w0_en), .w0_addr_i(w0_a), .w0_data_i(w0_d),
        .w1_en_i(w1_en), .w1_addr_i(w1_a), .w1_data_i(w1_d),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_a),
        .busy_cnt_o(cnt_b)
    );

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .ZERO_REG(1)) dut_n (
        .clk_i(clk), .rst_i(rst),
        .rs_addr_i(rs_a), .rt_addr_i(rt_a),
        .rs_data_o(rs_d_n), .rt_data_o(rt_d_n),
        .rs_busy_o(rs_bz_n), .rt_busy_o(rt_bz_n),
        .w0_en_i(w0_en), .w0_addr_i(w0_a), .w0_data_i(w0_d),
        .w1_en_i(w1_en), .w1_addr_i(w1_a), .w1_data_i(w1_d),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_a),
        .busy_cnt_o(cnt_n)
    );

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && w0_en && w0_a == a) return w0_d;
        if (byp && w1_en && w1_a == a) return w1_d;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && ((w0_en && w0_a == a) || (w1_en && w1_a == a))) return 1'b0;
        return busy_m[a];
    endfunction

    function automatic logic [AW:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(busy_m[i]);
        return (AW+1)'(n);
    endfunction

    // Architectural effect of one clock edge on the model.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_m[i]  = '0;
                busy_m[i] = 1'b0;
            end
        end else begin
            if (w1_en && w1_a != 0) begin mem_m[w1_a] = w1_d; busy_m[w1_a] = 1'b0; end
            if (w0_en && w0_a != 0) begin mem_m[w0_a] = w0_d; busy_m[w0_a] = 1'b0; end
            if (rsv_en && rsv_a != 0) busy_m[rsv_a] = 1'b1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; w0_en = 1'b0; w1_en = 1'b0; rsv_en = 1'b0;
        w0_a = '0; w1_a = '0; rsv_a = '0; w0_d = '0; w1_d = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; w0_en = 1'b1; w0_a = 5'd3; w0_d = 32'h1234;
        tick();
        idle();
        rs_a = 5'd5; rt_a = 5'd31;
        #1;
        checks++;
        if (rs_d_b !== 32'h0 || rt_d_b !== 32'h0) begin
            errors++; $display("FAIL reset_data got %h %h expected 0 0", rs_d_b, rt_d_b);
        end
        checks++;
        if (rs_bz_b !== 1'b0 || rt_bz_b !== 1'b0 || cnt_b !== '0 || cnt_n !== '0) begin
            errors++; $display("FAIL reset_busy got %b %b cnt %0d/%0d expected 0 0 cnt 0", rs_bz_b, rt_bz_b, cnt_b, cnt_n);
        end
        rs_a = 5'd3;
        #1;
        checks++;
        if (rs_d_b !== 32'h0 || rs_d_n !== 32'h0) begin
            errors++; $display("FAIL reset_overrides_write got %h/%h expected 0", rs_d_b, rs_d_n);
        end
    endtask

    task automatic test_dual_write();
        idle();
        w0_en = 1'b1; w0_a = 5'd7; w0_d = 32'hAAAA_0001;
        w1_en = 1'b1; w1_a = 5'd7; w1_d = 32'hBBBB_0002;
        tick();
        w0_a = 5'd8; w0_d = 32'h1;
        w1_a = 5'd9; w1_d = 32'h2;
        rs_a = 5'd7;
        #1;
        checks++;
        if (rs_d_n !== 32'hAAAA_0001) begin
            errors++; $display("FAIL collision_w0_wins got %h expected aaaa0001", rs_d_n);
        end
        tick();
        idle();
        rs_a = 5'd8; rt_a = 5'd9;
        #1;
        checks++;
        if (rs_d_n !== 32'h1 || rt_d_n !== 32'h2) begin
            errors++; $display("FAIL dual_write got %h %h expected 1 2", rs_d_n, rt_d_n);
        end
    endtask

    task automatic test_bypass();
        idle();
        w1_en = 1'b1; w1_a = 5'd4; w1_d = 32'hDEAD_BEEF;
        rs_a = 5'd4;
        #1;
        checks++;
        if (rs_d_b !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bypass_same_cycle got %h expected deadbeef", rs_d_b);
        end
        checks++;
        if (rs_d_n !== 32'h0) begin
            errors++; $display("FAIL nobypass_old_value got %h expected 0", rs_d_n);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs_d_n !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL nobypass_next_cycle got %h expected deadbeef", rs_d_n);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en = 1'b1; rsv_a = 5'd10; rt_a = 5'd10;
        #1;
        checks++;
        if (rt_bz_b !== 1'b0 || cnt_b !== 6'd0) begin
            errors++; $display("FAIL rsv_not_visible_same_cycle got busy %b cnt %0d expected 0 0", rt_bz_b, cnt_b);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rt_bz_b !== 1'b1 || rt_bz_n !== 1'b1 || cnt_b !== 6'd1) begin
            errors++; $display("FAIL rsv_busy got %b/%b cnt %0d expected 1 1 cnt 1", rt_bz_b, rt_bz_n, cnt_b);
        end
        w0_en = 1'b1; w0_a = 5'd10; w0_d = 32'h55;
        #1;
        checks++;
        if (rt_bz_b !== 1'b0 || rt_bz_n !== 1'b1 || cnt_b !== 6'd1) begin
            errors++; $display("FAIL release_comb got %b/%b cnt %0d expected 0 1 cnt 1", rt_bz_b, rt_bz_n, cnt_b);
        end
        tick();
        idle();
        #1;
        checks++;
        if (cnt_b !== 6'd0 || cnt_n !== 6'd0 || rt_bz_n !== 1'b0) begin
            errors++; $display("FAIL release_edge got cnt %0d/%0d busy %b expected 0 0 0", cnt_b, cnt_n, rt_bz_n);
        end
        rsv_en = 1'b1; rsv_a = 5'd10;
        w1_en = 1'b1; w1_a = 5'd10; w1_d = 32'h66;
        tick();
        idle();
        #1;
        checks++;
        if (rt_bz_b !== 1'b1 || cnt_b !== 6'd1 || cnt_n !== 6'd1) begin
            errors++; $display("FAIL rsv_beats_write got busy %b cnt %0d/%0d expected 1 1 1", rt_bz_b, cnt_b, cnt_n);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        w0_en = 1'b1; w0_a = 5'd0; w0_d = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_a = 5'd0; rs_a = 5'd0;
        #1;
        checks++;
        if (rs_d_b !== 32'h0 || rs_bz_b !== 1'b0) begin
            errors++; $display("FAIL zero_bypass got %h busy %b expected 0 0", rs_d_b, rs_bz_b);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs_d_n !== 32'h0 || rs_bz_n !== 1'b0 || cnt_b !== 6'd1) begin
            errors++; $display("FAIL zero_state got %h busy %b cnt %0d expected 0 0 1", rs_d_n, rs_bz_n, cnt_b);
        end
    endtask

    task automatic test_count();
        idle();
        rst = 1'b1;
        tick();
        idle();
        for (int a = 1; a < NREG; a++) begin
            rsv_en = 1'b1; rsv_a = AW'(a);
            tick();
        end
        rsv_en = 1'b1; rsv_a = 5'd5;
        tick();
        idle();
        #1;
        checks++;
        if (cnt_b !== 6'd31 || cnt_n !== 6'd31) begin
            errors++; $display("FAIL count_all got %0d/%0d expected 31", cnt_b, cnt_n);
        end
        w0_en = 1'b1; w0_a = 5'd1; w0_d = 32'h11;
        w1_en = 1'b1; w1_a = 5'd2; w1_d = 32'h22;
        rsv_en = 1'b1; rsv_a = 5'd1;
        tick();
        idle();
        rs_a = 5'd1; rt_a = 5'd2;
        #1;
        checks++;
        if (cnt_b !== 6'd30 || cnt_n !== 6'd30 || rs_bz_n !== 1'b1 || rt_bz_n !== 1'b0) begin
            errors++; $display("FAIL count_mixed got cnt %0d/%0d busy %b %b expected 30 1 0", cnt_b, cnt_n, rs_bz_n, rt_bz_n);
        end
        w0_en = 1'b1; w0_a = 5'd3; w0_d = 32'h33;
        w1_en = 1'b1; w1_a = 5'd4; w1_d = 32'h44;
        tick();
        idle();
        #1;
        checks++;
        if (cnt_b !== 6'd28) begin
            errors++; $display("FAIL count_dec2 got %0d expected 28", cnt_b);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 60) == 0);
            w0_en  = $urandom_range(0, 1) == 1;
            w1_en  = $urandom_range(0, 1) == 1;
            rsv_en = $urandom_range(0, 1) == 1;
            w0_d   = $urandom;
            w1_d   = $urandom;
            a = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31)); w0_a  = a;
            a = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31)); w1_a  = a;
            a = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31)); rsv_a = a;
            a = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31)); rs_a  = a;
            a = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31)); rt_a  = a;
            #1;
            checks++;
            if (rs_d_b !== exp_data(rs_a, 1'b1) || rt_d_b !== exp_data(rt_a, 1'b1)) begin
                errors++; $display("FAIL rand_data_byp n=%0d got %h %h expected %h %h", n, rs_d_b, rt_d_b, exp_data(rs_a, 1'b1), exp_data(rt_a, 1'b1));
            end
            checks++;
            if (rs_d_n !== exp_data(rs_a, 1'b0) || rt_d_n !== exp_data(rt_a, 1'b0)) begin
                errors++; $display("FAIL rand_data_nobyp n=%0d got %h %h expected %h %h", n, rs_d_n, rt_d_n, exp_data(rs_a, 1'b0), exp_data(rt_a, 1'b0));
            end
            checks++;
            if (rs_bz_b !== exp_busy(rs_a, 1'b1) || rt_bz_b !== exp_busy(rt_a, 1'b1)
                || rs_bz_n !== exp_busy(rs_a, 1'b0) || rt_bz_n !== exp_busy(rt_a, 1'b0)) begin
                errors++; $display("FAIL rand_busy n=%0d got %b%b %b%b expected %b%b %b%b", n, rs_bz_b, rt_bz_b, rs_bz_n, rt_bz_n,
                                   exp_busy(rs_a, 1'b1), exp_busy(rt_a, 1'b1), exp_busy(rs_a, 1'b0), exp_busy(rt_a, 1'b0));
            end
            checks++;
            if (cnt_b !== exp_cnt() || cnt_n !== exp_cnt()) begin
                errors++; $display("FAIL rand_cnt n=%0d got %0d/%0d expected %0d", n, cnt_b, cnt_n, exp_cnt());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rs_a = '0; rt_a = '0;
        rst = 1'b1;
        tick();
        tick();
        test_reset();
        test_dual_write();
        test_bypass();
        test_scoreboard();
        test_zero_reg();
        test_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
